// File: rtl/divider.sv
// divider -- multi-cycle 32-bit integer divider for DIV / DIVU.
//
// Radix-2 restoring division, one quotient bit per cycle: an accepted
// request produces its result 33 cycles later (2 cycles for a zero divisor).
// The result stays valid while start is held high.
//
// Ports:
//   clk        in   1   clock, rising edge
//   resetn     in   1   asynchronous active-low reset
//   start      in   1   divide request, held high until ready is seen
//   signed_div in   1   1 = two's complement (DIV), 0 = unsigned (DIVU)
//   annul      in   1   cancel the current operation (exception / flush)
//   opdata1    in  32   dividend
//   opdata2    in  32   divisor
//   result     out 64   {remainder [63:32], quotient [31:0]}, registered
//   ready      out  1   result valid, registered
//   stall      out  1   pipeline stall request, start & ~ready
module divider (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic        annul,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] part_q, part_d;   // {partial remainder [64:32], dividend/quotient [31:0]}
  logic [31:0] dvsr_q, dvsr_d;   // divisor magnitude
  logic        qneg_q, qneg_d;   // quotient needs negation
  logic        rneg_q, rneg_d;   // remainder needs negation
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [65:0] shift_s;
  logic [33:0] trial_s;
  logic [64:0] step_s;

  // Magnitude of a value that is two's complement when sgn is set.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) begin
      return ~v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Conditional two's complement negation (zero stays zero).
  function automatic logic [31:0] fix32(input logic [31:0] v, input logic neg);
    if (neg) begin
      return ~v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // One restoring step: shift in the next dividend bit, subtract the divisor
  // if it fits and record a 1 quotient bit, otherwise keep the shifted value.
  assign shift_s = {part_q, 1'b0};
  assign trial_s = shift_s[65:32] - {2'b00, dvsr_q};
  assign step_s  = trial_s[33] ? shift_s[64:0] : {trial_s[32:0], shift_s[31:1], 1'b1};

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    part_d   = part_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;
    if (annul) begin
      // Flush wins over everything, including a start in the same cycle.
      state_d  = S_IDLE;
      cnt_d    = 5'd0;
      part_d   = 65'd0;
      dvsr_d   = 32'd0;
      qneg_d   = 1'b0;
      rneg_d   = 1'b0;
      result_d = 64'd0;
      ready_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          result_d = 64'd0;
          ready_d  = 1'b0;
          if (start) begin
            cnt_d  = 5'd0;
            dvsr_d = mag32(opdata2, signed_div);
            qneg_d = signed_div & (opdata1[31] ^ opdata2[31]);
            rneg_d = signed_div & opdata1[31];
            if (opdata2 == 32'd0) begin
              // Raw dividend is kept so it can be returned as HI.
              state_d = S_DIVZERO;
              part_d  = {33'd0, opdata1};
            end else begin
              state_d = S_ON;
              part_d  = {33'd0, mag32(opdata1, signed_div)};
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DIVZERO: begin
          state_d  = S_END;
          result_d = {part_q[31:0], 32'hFFFF_FFFF};
          ready_d  = 1'b1;
        end
        S_ON: begin
          part_d = step_s;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = S_END;
            result_d = {fix32(step_s[63:32], rneg_q), fix32(step_s[31:0], qneg_q)};
            ready_d  = 1'b1;
          end else begin
            state_d = S_ON;
          end
        end
        S_END: begin
          if (start) begin
            state_d = S_END;
            ready_d = 1'b1;
          end else begin
            state_d  = S_IDLE;
            cnt_d    = 5'd0;
            result_d = 64'd0;
            ready_d  = 1'b0;
          end
        end
        default: begin
          state_d  = S_IDLE;
          cnt_d    = 5'd0;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      part_q   <= 65'd0;
      dvsr_q   <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      part_q   <= part_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign stall  = start & ~ready_q;

endmodule
